// File: rtl/simon_pkg.sv
// Shared types for the Simon player-input checker: colour codes, FSM states
// and small button-decoding helpers.
package simon_pkg;

    typedef logic [2:0] colour_t;

    localparam colour_t COL_0 = 3'b000;
    localparam colour_t COL_1 = 3'b001;
    localparam colour_t COL_2 = 3'b010;
    localparam colour_t COL_3 = 3'b011;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PRESS,
        DEBOUNCE,
        EVAL,
        WAIT_RELEASE
    } state_t;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    function automatic colour_t btn_to_colour(input logic [3:0] btn);
        colour_t c;
        case (btn)
            4'b0001: c = COL_0;
            4'b0010: c = COL_1;
            4'b0100: c = COL_2;
            4'b1000: c = COL_3;
            default: c = COL_0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer bringing the raw asynchronous buttons into clk.
module btn_sync (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] din,
    output logic [3:0] dout
);

    logic [3:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            dout <= '0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/player_check.sv
// Debounces player presses and checks them against the stored colour sequence.
// Optional per-press timeout is compiled in with PLAYER_TIMEOUT_EN.
//
// state        | meaning
// IDLE         | waiting for start, busy low
// WAIT_PRESS   | waiting for a single synchronized button
// DEBOUNCE     | latched button must stay unchanged DEBOUNCE_CYCLES clocks
// EVAL         | one cycle: compare code with segment[check_idx]
// WAIT_RELEASE | buttons must read zero DEBOUNCE_CYCLES clocks in a row
module player_check
    import simon_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [3:0]      player_input,
    input  logic [31:0][2:0] segment,
    input  logic [4:0]      round_len,
    input  logic            start,
    output logic            busy,
    output logic            code_valid,
    output logic [2:0]      code,
    output logic            match,
    output logic            mismatch,
    output logic            round_done,
    output logic            timeout,
    output logic [4:0]      check_idx
);

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be 1..255");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t     state_q, state_d;
    logic [3:0] btn_s;
    logic [3:0] latched_q, latched_d;
    logic [7:0] cnt_q, cnt_d;
    logic       ret_idle_q, ret_idle_d;
    logic [4:0] idx_d;
    colour_t    code_d;
    logic       code_valid_d, match_d, mismatch_d, round_done_d;
    logic       tmo_hit;

    btn_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (player_input),
        .dout    (btn_s)
    );

    assign busy = (state_q != IDLE);

`ifdef PLAYER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;

    assign tmo_hit = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

    // Budget covers the whole press: debounce restarts do not refill it.
    always_comb begin
        tcnt_d = tcnt_q;
        if (state_d == WAIT_PRESS && (state_q == IDLE || state_q == WAIT_RELEASE))
            tcnt_d = '0;
        else if (state_q == WAIT_PRESS || state_q == DEBOUNCE)
            tcnt_d = tcnt_q + TW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt_q  <= '0;
            timeout <= 1'b0;
        end else begin
            tcnt_q  <= tcnt_d;
            timeout <= tmo_hit && (state_q == WAIT_PRESS || state_q == DEBOUNCE);
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        latched_d    = latched_q;
        cnt_d        = cnt_q;
        ret_idle_d   = ret_idle_q;
        idx_d        = check_idx;
        code_d       = code;
        code_valid_d = 1'b0;
        match_d      = 1'b0;
        mismatch_d   = 1'b0;
        round_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_PRESS;
                    idx_d   = '0;
                end
            end
            WAIT_PRESS: begin
                if (tmo_hit) begin
                    mismatch_d = 1'b1;
                    state_d    = IDLE;
                end else if (is_onehot(btn_s)) begin
                    latched_d = btn_s;
                    cnt_d     = '0;
                    state_d   = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (tmo_hit) begin
                    mismatch_d = 1'b1;
                    state_d    = IDLE;
                end else if (btn_s != latched_q) begin
                    state_d = WAIT_PRESS;
                end else if (cnt_q == DB_LAST) begin
                    state_d = EVAL;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            EVAL: begin
                code_valid_d = 1'b1;
                code_d       = btn_to_colour(latched_q);
                cnt_d        = '0;
                state_d      = WAIT_RELEASE;
                if (btn_to_colour(latched_q) == segment[check_idx]) begin
                    if (check_idx == round_len) begin
                        round_done_d = 1'b1;
                        ret_idle_d   = 1'b1;
                    end else begin
                        match_d    = 1'b1;
                        idx_d      = check_idx + 5'd1;
                        ret_idle_d = 1'b0;
                    end
                end else begin
                    mismatch_d = 1'b1;
                    ret_idle_d = 1'b1;
                end
            end
            WAIT_RELEASE: begin
                if (btn_s != 4'b0000)
                    cnt_d = '0;
                else if (cnt_q == DB_LAST)
                    state_d = ret_idle_q ? IDLE : WAIT_PRESS;
                else
                    cnt_d = cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            latched_q  <= '0;
            cnt_q      <= '0;
            ret_idle_q <= 1'b0;
            check_idx  <= '0;
            code       <= COL_0;
            code_valid <= 1'b0;
            match      <= 1'b0;
            mismatch   <= 1'b0;
            round_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            latched_q  <= latched_d;
            cnt_q      <= cnt_d;
            ret_idle_q <= ret_idle_d;
            check_idx  <= idx_d;
            code       <= code_d;
            code_valid <= code_valid_d;
            match      <= match_d;
            mismatch   <= mismatch_d;
            round_done <= round_done_d;
        end
    end

endmodule

// File: doc/player_check.md
PLAYER_CHECK -- requirements
Module: player_check

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the number of clocks a synchronized input must hold steady to be accepted (range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the number of clocks allowed per press when the timeout is compiled in.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port player_input, input, 4 bits: raw active-high buttons, asynchronous to clk.
REQ-006 SHALL have port segment, input, [31:0][2:0]: the stored colour sequence, one 3-bit code per step.
REQ-007 SHALL have port round_len, input, 5 bits: index of the last step in the current round.
REQ-008 SHALL have port start, input, 1 bit: a one-cycle pulse that begins checking a round.
REQ-009 SHALL have outputs busy (1 bit), code_valid (1), code (3), match (1), mismatch (1), round_done (1), timeout (1) and check_idx (5).

Function
REQ-010 SHALL pass player_input through a 2-flop synchronizer before any use.
REQ-011 SHALL implement the FSM states IDLE, WAIT_PRESS, DEBOUNCE, EVAL and WAIT_RELEASE.
REQ-012 IDLE: busy=0; start=1 -> WAIT_PRESS with check_idx=0.
- start is ignored in every other state.
REQ-013 WAIT_PRESS: a one-hot synchronized input -> DEBOUNCE, with the value latched and the counter cleared.
- All-zero or multi-hot input -> stay in WAIT_PRESS.
REQ-014 DEBOUNCE: the counter increments while the synchronized input equals the latched value.
- Input changes -> WAIT_PRESS.
- Counter reaches DEBOUNCE_CYCLES-1 with the input unchanged -> EVAL.
REQ-015 SHALL encode the latched button as code: bit0->000, bit1->001, bit2->010, bit3->011.
REQ-016 EVAL lasts 1 cycle:
- code_valid=1.
- Compare code with segment[check_idx].
REQ-017 In EVAL, on equal with check_idx != round_len:
- match pulse.
- check_idx increments.
- -> WAIT_RELEASE, then WAIT_PRESS.
REQ-018 In EVAL, on equal with check_idx == round_len: round_done pulse; -> WAIT_RELEASE, then IDLE.
REQ-019 In EVAL, on not-equal:
- mismatch pulse.
- check_idx holds its value.
- -> WAIT_RELEASE, then IDLE.
REQ-020 WAIT_RELEASE: exit only after the synchronized input has been all-zero for DEBOUNCE_CYCLES consecutive clocks; any nonzero input restarts the count.
REQ-021 The match, mismatch, round_done and code_valid pulses SHALL all be single-cycle, mutually exclusive except code_valid, and registered.
REQ-022 Latency: a clean one-hot press stable from clk edge t SHALL produce its EVAL pulses on edge t+DEBOUNCE_CYCLES+3.
REQ-023 code SHALL hold its last value until the next EVAL.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 round_len=0 SHALL make the first correct press produce round_done, with no match pulse.

Reset
REQ-026 reset_n low SHALL force IDLE immediately, from any state including mid-debounce.
REQ-027 During reset, all outputs and counters SHALL be 0 and the synchronizer flops SHALL clear.
REQ-028 After reset release, no pulse SHALL occur until a start is received.

Configuration
REQ-029 With PLAYER_TIMEOUT_EN defined, a counter SHALL run in WAIT_PRESS and DEBOUNCE and clear on entry to WAIT_PRESS from WAIT_RELEASE or IDLE.
REQ-030 With PLAYER_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL pulse timeout and mismatch together for one cycle and then go to IDLE.
REQ-031 Without PLAYER_TIMEOUT_EN, timeout SHALL be tied 0 and no timeout counter SHALL be synthesized.

Structure
REQ-032 Package simon_pkg SHALL hold:
- colour_t (3-bit typedef);
- constants COL_0..COL_3 = 000..011;
- the FSM state enum.
REQ-033 The 2-flop synchronizer SHALL be the sub-module btn_sync, which is 4 bits wide and reset by reset_n.

Verification (DEBOUNCE_CYCLES=4)
REQ-034 Bench SHALL cover: segment[0..2]={001,011,000}, round_len=2, start, then presses 0010, 1000, 0001 -> match, match, round_done, with check_idx 1, 2, then IDLE.
REQ-035 Bench SHALL cover: segment[0]=010, press 0001 -> code=000, mismatch pulse, busy falls after release.
REQ-036 Bench SHALL cover: 2-cycle glitch on 0100 followed by 0 -> no code_valid; multi-hot 0110 held -> no code_valid.
REQ-037 Bench SHALL cover: press stable at edge t -> code_valid exactly at edge t+7; reset_n low during DEBOUNCE -> all outputs 0 and busy 0 at once.
REQ-038 Bench SHALL cover: with PLAYER_TIMEOUT_EN and TIMEOUT_CYCLES=20, start then no press -> timeout and mismatch pulse together 20 clocks later, then IDLE.
REQ-039 Bench SHALL cover: start pulsed while busy -> check_idx is unaffected.
